// File: rtl/instr_fetch_unit_if.sv
// Instruction fetch bus: memory read port and instruction stream toward the processor.
// master = fetch unit side, slave = memory/consumer side.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 5
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_q;
  logic [15:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    output mem_rd_en, mem_addr, instr, instr_pc, instr_valid,
    input  mem_q, instr_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, instr, instr_pc, instr_valid,
    output mem_q, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Prefetching instruction fetch unit: sequential reads into a small FIFO with redirect flush.
// Optional FETCH_PERF_CNT_EN adds a 16-bit delivered-instruction counter on fetch_count.
module instr_fetch_unit #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      run,
  input  logic                      redirect_valid,
  input  logic [ADDR_W-1:0]         redirect_addr,
  instr_fetch_unit_if.master        bus,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [15:0]               fetch_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fetch_addr;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [15:0]       fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];
  logic              issue;
  logic              wr;
  logic              xfer;
  logic              valid;

  // The in-flight read is reserved against capacity so a response always has a slot.
  assign valid = (count != '0);
  assign issue = reset_n & run & ~redirect_valid &
                 ((count + CNT_W'(inflight)) < CNT_W'(DEPTH));
  assign wr    = inflight & ~redirect_valid;
  assign xfer  = valid & bus.instr_ready;

  assign bus.mem_rd_en   = issue;
  assign bus.mem_addr    = reset_n ? fetch_addr : '0;
  assign bus.instr_valid = valid;
  assign bus.instr       = valid ? fifo_data[head] : '0;
  assign bus.instr_pc    = valid ? fifo_pc[head]   : '0;
  assign fifo_count      = count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_addr <= '0;
      inflight   <= 1'b0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else begin
      inflight <= issue;
      if (redirect_valid) begin
        fetch_addr <= redirect_addr;
        head       <= '0;
        tail       <= '0;
        count      <= '0;
      end else begin
        if (issue) fetch_addr <= fetch_addr + ADDR_W'(1);
        if (wr)    tail       <= tail + PTR_W'(1);
        if (xfer)  head       <= head + PTR_W'(1);
        if (wr && !xfer)      count <= count + CNT_W'(1);
        else if (!wr && xfer) count <= count - CNT_W'(1);
      end
    end
  end

  // Storage is never reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (issue) inflight_pc <= fetch_addr;
    if (wr) begin
      fifo_data[tail] <= bus.mem_q;
      fifo_pc[tail]   <= inflight_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)  perf_cnt <= '0;
    else if (xfer) perf_cnt <= perf_cnt + 16'd1;
  end

  assign fetch_count = perf_cnt;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 5, is the instruction memory address width (32 words).
REQ-002 Parameter DEPTH, default 4, is the prefetch buffer depth in 16-bit words (power of two, at least 2).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 run  input  1  fetch enable; new memory reads are issued only while high.
REQ-006 mem_rd_en  output  1  read strobe to synchronous instruction memory.
REQ-007 mem_addr  output  ADDR_W  read address to instruction memory.
REQ-008 mem_q  input  16  memory read data, valid exactly one cycle after mem_rd_en.
REQ-009 instr  output  16  instruction word at buffer head, feeding the processor DIN.
REQ-010 instr_pc  output  ADDR_W  address the head instruction was fetched from.
REQ-011 instr_valid  output  1  buffer head holds a valid instruction.
REQ-012 instr_ready  input  1  consumer (control FSM IR load) accepts head this cycle.
REQ-013 redirect_valid  input  1  branch/jump request: flush and restart fetch.
REQ-014 redirect_addr  input  ADDR_W  restart address.
REQ-015 fifo_count  output  clog2(DEPTH)+1  number of buffered valid words.
REQ-016 fetch_count  output  16  delivered-instruction counter (see Configuration).

Function
REQ-017 Issue: mem_rd_en SHALL be high in a cycle iff run=1, redirect_valid=0 and fifo_count + in-flight reads < DEPTH.
REQ-018 Each issue SHALL drive mem_addr = fetch address and advance fetch address by 1, wrapping from 2^ADDR_W-1 to 0.
REQ-019 At most one read SHALL be in flight; its mem_q word and address SHALL be written to the buffer tail in the cycle mem_q is valid.
REQ-020 A written word SHALL appear at instr with instr_valid=1 in the cycle after it is written (no bypass); first instruction after reset is visible 2 cycles after the first issue.
REQ-021 Transfer SHALL occur on instr_valid & instr_ready; head then advances in order, FIFO order preserved.
REQ-022 Simultaneous write and transfer SHALL leave fifo_count unchanged; fifo_count SHALL never exceed DEPTH nor underflow.
REQ-023 instr_ready while instr_valid=0 SHALL have no effect.
REQ-024 Redirect: in a cycle with redirect_valid=1 the buffer SHALL be flushed, any in-flight response SHALL be discarded when it arrives, and fetch address SHALL become redirect_addr.
REQ-025 A transfer coinciding with redirect_valid SHALL complete (consumer keeps the word); instr_valid SHALL be 0 in the following cycle.
REQ-026 First issue after redirect SHALL occur the cycle after redirect_valid (if run=1), at redirect_addr.
REQ-027 run falling SHALL stop new issues only; an in-flight response SHALL still be buffered and buffered words still delivered.

Reset
REQ-028 With reset_n=0 at a clock edge: fetch address=0, buffer empty, in-flight flag cleared, fetch_count=0.
REQ-029 During and after reset: mem_rd_en=0, mem_addr=0, instr=0, instr_pc=0, instr_valid=0, fifo_count=0.
REQ-030 Reset mid-operation SHALL discard in-flight and buffered words; reset SHALL override redirect and run.

Configuration
REQ-031 With FETCH_PERF_CNT_EN defined, fetch_count SHALL increment by 1 on every transfer, wrapping 0xFFFF to 0, cleared only by reset.
REQ-032 Without FETCH_PERF_CNT_EN, fetch_count SHALL be constant 0 and no counter register SHALL be synthesised.

Verification
REQ-033 Reset release, run=1, instr_ready=1, memory[i]=0x1000+i -> issue at addr 0 cycle 0, instr=0x1000, instr_pc=0 valid cycle 2, then one word per cycle 0x1001, 0x1002...
REQ-034 instr_ready=0, run=1 -> exactly 4 reads issued (addr 0..3), fifo_count=4, mem_rd_en=0 thereafter; ready=1 -> words 0x1000..0x1003 in order.
REQ-035 Buffer holding addr 5..7, redirect_valid=1 with redirect_addr=0x10 while read of addr 8 in flight -> addr 8 word dropped, instr_valid=0 next cycle, next issue addr 0x10, next delivered instr_pc=0x10.
REQ-036 Fetch from addr 30 onward -> mem_addr sequence 30, 31, 0, 1; instr_pc follows.
REQ-037 run=0 after issue of addr 2 -> addr 2 word still delivered, no further mem_rd_en; reset_n=0 mid-stream -> all outputs 0 next cycle, restart at addr 0.
REQ-038 FETCH_PERF_CNT_EN defined, 10 transfers -> fetch_count=10; macro undefined -> fetch_count=0.
